pipe_if_id: RTL and testbench
=============================

PIPE_IF_ID -- requirements
Module: pipe_IF_ID

Interface
REQ-001 SHALL use one clock and a synchronous, active-low reset: one clock; reset is synchronous and active-low.
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port rst  input  1  synchronous active-low reset; sampled on the clk rising edge only.
REQ-004 Port instruction  input  16  fetched instruction word from instruction memory.
REQ-005 Port PC  input  16  address of the fetched instruction.
REQ-006 Port PC_plus2  input  16  PC+2 from the fetch adder.
REQ-007 Port if_valid  input  1  instruction, PC, PC_plus2 and inst_mis_align are valid this cycle.
REQ-008 Port if_stall  input  1  instruction memory busy; no valid word this cycle.
REQ-009 Port inst_mis_align  input  1  fetch-address misalignment error for this word.
REQ-010 Port stall_decode  input  1  decode hazard; hold the IF/ID contents.
REQ-011 Port flush  input  1  taken branch, jump or exception resolved downstream; squash IF/ID.
REQ-012 Ports instruction_o, PC_o, PC_plus2_o  output  16 each  registered copies for decode.
REQ-013 Port valid_o  output  1  instruction_o holds a real instruction, not a bubble.
REQ-014 Port inst_mis_align_o  output  1  registered misalignment flag.
REQ-015 Port pc_hold  output  1  combinational; tells fetch to hold PC.
REQ-016 Port halted_o  output  1  registered; FSM is in HALT.

Function
REQ-017 SHALL implement a 4-state FSM: RUN, WAIT (memory busy), DROP (discard the next returning word), HALT (a halt instruction has been captured).
REQ-018 Bubble load SHALL mean: instruction_o=16'h0800 (NOP), valid_o=0 and inst_mis_align_o=0, with PC_o and PC_plus2_o unchanged.
REQ-019 Capture SHALL mean: load instruction, PC, PC_plus2 and inst_mis_align into the output registers and set valid_o=1; the values appear one cycle after the capture edge.
REQ-020 Per-cycle priority SHALL be: rst, then flush, then stall_decode, then if_valid.
REQ-021 RUN: flush -> bubble, next state DROP if if_stall=1, otherwise RUN.
REQ-022 RUN: stall_decode -> hold all output registers, next state WAIT if if_stall=1, otherwise RUN.
REQ-023 RUN: if_valid -> capture; otherwise -> bubble, next state WAIT if if_stall=1.
REQ-024 WAIT: flush -> bubble and DROP; stall_decode -> hold and stay WAIT; if_valid -> capture and RUN; otherwise -> bubble and stay WAIT.
REQ-025 DROP: every cycle -> bubble, including cycles with stall_decode asserted.
REQ-026 DROP: if_valid with no flush -> discard the word and go to RUN; flush -> stay DROP.
REQ-027 Any capture with instruction[15:11]=5'b00000 (HALT) SHALL go to HALT instead of RUN.
REQ-028 HALT: flush -> bubble, next state DROP if if_stall=1, otherwise RUN (a speculative halt is cancelled).
REQ-029 HALT: stall_decode -> hold; otherwise -> bubble; if_valid words are never captured in HALT.
REQ-030 pc_hold SHALL equal stall_decode OR (state==HALT), and SHALL be 0 whenever flush=1.
REQ-031 halted_o SHALL be 1 exactly when state==HALT.
REQ-032 Simultaneous flush and if_valid SHALL discard that word.
REQ-033 Simultaneous stall_decode and if_valid (no flush) SHALL keep the old contents; fetch re-presents the word because pc_hold=1.

Reset
REQ-034 While rst=0 at a clk edge, the block SHALL set: state=RUN, instruction_o=16'h0800, PC_o=0, PC_plus2_o=0, valid_o=0, inst_mis_align_o=0, halted_o=0.
REQ-035 Reset SHALL override flush, stall_decode and any in-progress WAIT, DROP or HALT.
REQ-036 The first capture after reset release SHALL be possible in the first cycle with rst=1.

Verification
REQ-037 Reset, then if_valid=1, instruction=16'h4123, PC=16'h0010, PC_plus2=16'h0012 -> next cycle instruction_o=4123, PC_o=0010, PC_plus2_o=0012, valid_o=1.
REQ-038 Captured 16'h4123, then stall_decode=1 for 3 cycles with if_valid=1 and instruction=16'h5555 -> outputs stay 4123/valid_o=1 and pc_hold=1 in all 3 cycles.
REQ-039 if_stall=1 (enter WAIT), flush=1 next cycle, then if_valid=1 with 16'h6666 -> that word is dropped, instruction_o=0800/valid_o=0, FSM back in RUN; the following if_valid word is captured.
REQ-040 Capture 16'h0000 -> halted_o=1 and pc_hold=1; further if_valid words give NOP/valid_o=0; flush=1 -> halted_o=0, pc_hold=0, and the next word is captured.
REQ-041 if_valid=1 with inst_mis_align=1 -> inst_mis_align_o=1 next cycle; the same cycle with flush=1 -> inst_mis_align_o=0.
REQ-042 rst=0 asserted while in HALT with stall_decode=1 -> every output at its REQ-034 value on the next edge.

Source files
------------

// File: rtl/pipe_if_id.sv
// IF/ID pipeline register with a small fetch-side control FSM.
// The FSM tracks whether instruction memory is busy (WAIT), whether the next
// returning word must be thrown away after a redirect (DROP), and whether a
// halt instruction is sitting in decode (HALT). Every cycle it picks one of
// three actions for the IF/ID registers: hold, load a bubble, or capture.
module pipe_if_id (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  input  logic [15:0] PC,
  input  logic [15:0] PC_plus2,
  input  logic        if_valid,
  input  logic        if_stall,
  input  logic        inst_mis_align,
  input  logic        stall_decode,
  input  logic        flush,
  output logic [15:0] instruction_o,
  output logic [15:0] PC_o,
  output logic [15:0] PC_plus2_o,
  output logic        valid_o,
  output logic        inst_mis_align_o,
  output logic        pc_hold,
  output logic        halted_o
);

  localparam logic [15:0] NOP_WORD = 16'h0800;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_DROP,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_CAPTURE
  } act_t;

  state_t state_q;
  state_t state_d;
  act_t   act;
  state_t capture_next;

  // A captured halt opcode parks the FSM in HALT instead of RUN.
  assign capture_next = (instruction[15:11] == 5'b00000) ? S_HALT : S_RUN;

  // Fetch must not advance while decode stalls or a halt is in decode; a flush
  // always releases fetch so the redirect target can be fetched.
  assign pc_hold = !flush && (stall_decode || (state_q == S_HALT));

  // Next-state and register action, priority flush > stall_decode > if_valid.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    state_d = state_q;
    act     = ACT_BUBBLE;
    case (state_q)
      S_RUN: begin
        if (flush) begin
          act     = ACT_BUBBLE;
          state_d = if_stall ? S_DROP : S_RUN;
        end else if (stall_decode) begin
          act     = ACT_HOLD;
          state_d = if_stall ? S_WAIT : S_RUN;
        end else if (if_valid) begin
          act     = ACT_CAPTURE;
          state_d = capture_next;
        end else begin
          act     = ACT_BUBBLE;
          state_d = if_stall ? S_WAIT : S_RUN;
        end
      end
      S_WAIT: begin
        if (flush) begin
          act     = ACT_BUBBLE;
          state_d = S_DROP;
        end else if (stall_decode) begin
          act     = ACT_HOLD;
          state_d = S_WAIT;
        end else if (if_valid) begin
          act     = ACT_CAPTURE;
          state_d = capture_next;
        end else begin
          act     = ACT_BUBBLE;
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        // The word in flight belongs to the squashed path: always bubble, and
        // return to RUN once it has arrived unless a new flush restarts the drop.
        act = ACT_BUBBLE;
        if (flush) begin
          state_d = S_DROP;
        end else if (if_valid) begin
          state_d = S_RUN;
        end else begin
          state_d = S_DROP;
        end
      end
      S_HALT: begin
        if (flush) begin
          act     = ACT_BUBBLE;
          state_d = if_stall ? S_DROP : S_RUN;
        end else if (stall_decode) begin
          act     = ACT_HOLD;
          state_d = S_HALT;
        end else begin
          act     = ACT_BUBBLE;
          state_d = S_HALT;
        end
      end
      default: begin
        act     = ACT_BUBBLE;
        state_d = S_RUN;
      end
    endcase
  end

  // State and IF/ID registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q          <= S_RUN;
      instruction_o    <= NOP_WORD;
      PC_o             <= 16'h0000;
      PC_plus2_o       <= 16'h0000;
      valid_o          <= 1'b0;
      inst_mis_align_o <= 1'b0;
      halted_o         <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_o <= (state_d == S_HALT);
      case (act)
        ACT_CAPTURE: begin
          instruction_o    <= instruction;
          PC_o             <= PC;
          PC_plus2_o       <= PC_plus2;
          valid_o          <= 1'b1;
          inst_mis_align_o <= inst_mis_align;
        end
        ACT_BUBBLE: begin
          instruction_o    <= NOP_WORD;
          valid_o          <= 1'b0;
          inst_mis_align_o <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_if_id.sv
// Self-checking bench for pipe_if_id: a directed table of vectors with
// hand-derived expectations, followed by randomized cycles checked against a
// behavioural model of the IF/ID stage.
module tb_pipe_if_id;

  logic        clk;
  logic        rst;
  logic [15:0] instruction;
  logic [15:0] PC;
  logic [15:0] PC_plus2;
  logic        if_valid;
  logic        if_stall;
  logic        inst_mis_align;
  logic        stall_decode;
  logic        flush;
  logic [15:0] instruction_o;
  logic [15:0] PC_o;
  logic [15:0] PC_plus2_o;
  logic        valid_o;
  logic        inst_mis_align_o;
  logic        pc_hold;
  logic        halted_o;

  int n_vec;
  int n_err;

  pipe_if_id dut (
    .clk              (clk),
    .rst              (rst),
    .instruction      (instruction),
    .PC               (PC),
    .PC_plus2         (PC_plus2),
    .if_valid         (if_valid),
    .if_stall         (if_stall),
    .inst_mis_align   (inst_mis_align),
    .stall_decode     (stall_decode),
    .flush            (flush),
    .instruction_o    (instruction_o),
    .PC_o             (PC_o),
    .PC_plus2_o       (PC_plus2_o),
    .valid_o          (valid_o),
    .inst_mis_align_o (inst_mis_align_o),
    .pc_hold          (pc_hold),
    .halted_o         (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus what must be seen: pc_hold before the edge,
  // the registered outputs after it.
  typedef struct {
    logic        rst;
    logic        flush;
    logic        sd;
    logic        iv;
    logic        is;
    logic        mis;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc2;
    logic        e_hold;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    logic [15:0] e_pc2;
    logic        e_valid;
    logic        e_mis;
    logic        e_halted;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic fl, input logic sd, input logic iv,
                              input logic is, input logic mis, input logic [15:0] instr,
                              input logic [15:0] pc, input logic [15:0] pc2, input logic eh,
                              input logic [15:0] ei, input logic [15:0] epc, input logic [15:0] epc2,
                              input logic ev, input logic em, input logic eht);
    vec_t v;
    v.rst = r; v.flush = fl; v.sd = sd; v.iv = iv; v.is = is; v.mis = mis;
    v.instr = instr; v.pc = pc; v.pc2 = pc2;
    v.e_hold = eh; v.e_instr = ei; v.e_pc = epc; v.e_pc2 = epc2;
    v.e_valid = ev; v.e_mis = em; v.e_halted = eht;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst            = v.rst;
    flush          = v.flush;
    stall_decode   = v.sd;
    if_valid       = v.iv;
    if_stall       = v.is;
    inst_mis_align = v.mis;
    instruction    = v.instr;
    PC             = v.pc;
    PC_plus2       = v.pc2;
    #1;
    check("pc_hold", idx, {15'd0, pc_hold}, {15'd0, v.e_hold});
    @(posedge clk);
    #1;
    n_vec++;
    check("instruction_o", idx, instruction_o, v.e_instr);
    check("PC_o", idx, PC_o, v.e_pc);
    check("PC_plus2_o", idx, PC_plus2_o, v.e_pc2);
    check("valid_o", idx, {15'd0, valid_o}, {15'd0, v.e_valid});
    check("inst_mis_align_o", idx, {15'd0, inst_mis_align_o}, {15'd0, v.e_mis});
    check("halted_o", idx, {15'd0, halted_o}, {15'd0, v.e_halted});
  endtask

  // Behavioural model: three flags describe where fetch stands.
  bit          m_waiting;
  bit          m_dropping;
  bit          m_halted;
  logic [15:0] m_instr;
  logic [15:0] m_pc;
  logic [15:0] m_pc2;
  bit          m_valid;
  bit          m_mis;

  task automatic m_bubble();
    m_instr = 16'h0800;
    m_valid = 1'b0;
    m_mis   = 1'b0;
  endtask

  task automatic model_step(inout vec_t v);
    v.e_hold = !v.flush && (v.sd || m_halted);
    if (!v.rst) begin
      m_waiting = 0; m_dropping = 0; m_halted = 0;
      m_pc = 16'h0000; m_pc2 = 16'h0000;
      m_bubble();
    end else if (v.flush) begin
      m_bubble();
      m_dropping = m_waiting || m_dropping || v.is;
      m_waiting  = 0;
      m_halted   = 0;
    end else if (m_dropping) begin
      m_bubble();
      if (v.iv) m_dropping = 0;
    end else if (v.sd) begin
      if (!m_halted && !m_waiting) m_waiting = v.is;
    end else if (m_halted) begin
      m_bubble();
    end else if (v.iv) begin
      m_instr = v.instr; m_pc = v.pc; m_pc2 = v.pc2;
      m_valid = 1'b1; m_mis = v.mis;
      m_waiting = 0;
      m_halted  = (v.instr[15:11] == 5'b00000);
    end else begin
      m_bubble();
      if (!m_waiting) m_waiting = v.is;
    end
    v.e_instr = m_instr; v.e_pc = m_pc; v.e_pc2 = m_pc2;
    v.e_valid = m_valid; v.e_mis = m_mis; v.e_halted = m_halted;
  endtask

  vec_t vecs[$];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0; flush = 1'b0; stall_decode = 1'b0; if_valid = 1'b0; if_stall = 1'b0;
    inst_mis_align = 1'b0; instruction = 16'h0; PC = 16'h0; PC_plus2 = 16'h0;

    //                rst fl sd iv is mis instr     pc        pc2       hold e_instr   e_pc      e_pc2     v  m  h
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 16'h1234, 16'h0022, 16'h0024, 0, 16'h0800, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 16'h4123, 16'h0010, 16'h0012, 0, 16'h4123, 16'h0010, 16'h0012, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 16'h5555, 16'h0014, 16'h0016, 1, 16'h4123, 16'h0010, 16'h0012, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 16'h5555, 16'h0014, 16'h0016, 1, 16'h4123, 16'h0010, 16'h0012, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 16'h5555, 16'h0014, 16'h0016, 1, 16'h4123, 16'h0010, 16'h0012, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0800, 16'h0010, 16'h0012, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0800, 16'h0010, 16'h0012, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 16'h6666, 16'h0020, 16'h0022, 0, 16'h0800, 16'h0010, 16'h0012, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 16'h7777, 16'h0024, 16'h0026, 0, 16'h7777, 16'h0024, 16'h0026, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0028, 16'h002a, 0, 16'h0000, 16'h0028, 16'h002a, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 16'h1111, 16'h002c, 16'h002e, 1, 16'h0800, 16'h0028, 16'h002a, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 16'h2222, 16'h0030, 16'h0032, 0, 16'h0800, 16'h0028, 16'h002a, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 16'h3333, 16'h0030, 16'h0032, 0, 16'h3333, 16'h0030, 16'h0032, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 16'h4444, 16'h0031, 16'h0033, 0, 16'h4444, 16'h0031, 16'h0033, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 16'h4545, 16'h0035, 16'h0037, 0, 16'h0800, 16'h0031, 16'h0033, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0040, 16'h0042, 0, 16'h0000, 16'h0040, 16'h0042, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 16'h5678, 16'h0044, 16'h0046, 1, 16'h0800, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 16'h4123, 16'h0010, 16'h0012, 0, 16'h4123, 16'h0010, 16'h0012, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0800, 16'h0010, 16'h0012, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 16'h9999, 16'h0050, 16'h0052, 1, 16'h0800, 16'h0010, 16'h0012, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 16'h9999, 16'h0050, 16'h0052, 0, 16'h9999, 16'h0050, 16'h0052, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0800, 16'h0050, 16'h0052, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0800, 16'h0050, 16'h0052, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 16'hcccc, 16'h0054, 16'h0056, 0, 16'h0800, 16'h0050, 16'h0052, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 16'haaaa, 16'h0058, 16'h005a, 0, 16'h0800, 16'h0050, 16'h0052, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 16'hbbbb, 16'h0060, 16'h0062, 0, 16'hbbbb, 16'h0060, 16'h0062, 1, 0, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Randomized phase: the first cycle is a reset so the model starts in step.
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      v.rst   = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      v.flush = ($urandom_range(0, 9) == 0);
      v.sd    = ($urandom_range(0, 4) == 0);
      v.iv    = ($urandom_range(0, 2) != 0);
      v.is    = ($urandom_range(0, 3) == 0);
      v.mis   = ($urandom_range(0, 7) == 0);
      v.instr = 16'($urandom);
      if ($urandom_range(0, 7) == 0) v.instr[15:11] = 5'b00000;
      v.pc    = 16'($urandom);
      v.pc2   = v.pc + 16'd2;
      model_step(v);
      apply(v, 1000 + i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
